// File: rtl/dai.sv
// Month decoder: 31-day flag, day count and illegal-month flag, with
// enable-gated registered copies and a wrapping counter of enabled 31-day cycles.
module dai #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       month,
  input  logic             leap,
  input  logic             en,
  output logic             d,
  output logic [4:0]       days,
  output logic             invalid,
  output logic             d_q,
  output logic [4:0]       days_q,
  output logic             invalid_q,
  output logic [CNT_W-1:0] big_cnt
);

  logic [CNT_W-1:0] big_cnt_q, big_cnt_d;

  // d and invalid look at month alone so unknowns on leap/en/clk never reach them.
  always_comb begin
    d       = 1'b0;
    invalid = 1'b0;
    case (month)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: d = 1'b1;
      4'd2, 4'd4, 4'd6, 4'd9, 4'd11:              d = 1'b0;
      default:                                    invalid = 1'b1;
    endcase
  end

  always_comb begin
    days = 5'd0;
    if (d)
      days = 5'd31;
    else if (month == 4'd2)
      days = leap ? 5'd29 : 5'd28;
    else if (!invalid)
      days = 5'd30;
  end

  assign big_cnt_d = big_cnt_q + CNT_W'(en & d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q       <= 1'b0;
      days_q    <= 5'd0;
      invalid_q <= 1'b0;
      big_cnt_q <= '0;
    end else begin
      big_cnt_q <= big_cnt_d;
      if (en) begin
        d_q       <= d;
        days_q    <= days;
        invalid_q <= invalid;
      end
    end
  end

  assign big_cnt = big_cnt_q;

endmodule

// File: tb/tb_dai.sv
// Directed bench for dai: combinational decode checks plus a scoreboard of
// expected registered outputs pushed before each clock edge and popped after it.
module tb_dai;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst;
  logic [3:0] month;
  logic       leap;
  logic       en;
  logic       d;
  logic [4:0] days;
  logic       invalid;
  logic       d_q;
  logic [4:0] days_q;
  logic       invalid_q;
  logic [7:0] big_cnt;

  dai #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .month(month), .leap(leap), .en(en),
    .d(d), .days(days), .invalid(invalid),
    .d_q(d_q), .days_q(days_q), .invalid_q(invalid_q), .big_cnt(big_cnt)
  );

  initial forever begin
    #5;
    if (clk_run) clk = ~clk;
  end

  typedef struct packed {
    logic       d;
    logic [4:0] days;
    logic       inv;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Calendar reference: month lengths for a common year, 0 for illegal codes.
  int len_tab[16] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31, 0, 0, 0};
  int d_tab[12]   = '{1, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1};

  logic       m_dq;
  logic [4:0] m_days;
  logic       m_inv;
  logic [7:0] m_cnt;

  function automatic int ref_days(input logic [3:0] m, input logic lp);
    int n;
    n = len_tab[m];
    if (m == 4'd2 && lp) n = 29;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dq = 1'b0; m_days = 5'd0; m_inv = 1'b0; m_cnt = 8'd0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".d_q"}, 32'(d_q), 32'(m_dq));
    check({tag, ".days_q"}, 32'(days_q), 32'(m_days));
    check({tag, ".invalid_q"}, 32'(invalid_q), 32'(m_inv));
    check({tag, ".big_cnt"}, 32'(big_cnt), 32'(m_cnt));
  endtask

  // One enabled-or-not clock: predict, push, wait for the edge, pop, compare.
  task automatic tick(input string tag);
    exp_t e;
    int   n;
    if (en) begin
      n      = ref_days(month, leap);
      m_dq   = (n == 31);
      m_days = 5'(n);
      m_inv  = (len_tab[month] == 0);
      if (n == 31) m_cnt = m_cnt + 8'd1;
    end
    sb.push_back('{d: m_dq, days: m_days, inv: m_inv, cnt: m_cnt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".d_q"}, 32'(d_q), 32'(e.d));
    check({tag, ".days_q"}, 32'(days_q), 32'(e.days));
    check({tag, ".invalid_q"}, 32'(invalid_q), 32'(e.inv));
    check({tag, ".big_cnt"}, 32'(big_cnt), 32'(e.cnt));
    $display("tick %-8s month=%0d en=%0d -> d_q=%0d days_q=%0d invalid_q=%0d big_cnt=%0d",
             tag, month, en, d_q, days_q, invalid_q, big_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ill [3];
    ill = '{4'd0, 4'd13, 4'd15};

    // Reset held, clock stopped: registers cleared, decode still live.
    rst = 1'b1; en = 1'bx; leap = 1'bx; month = 4'd0;
    model_reset();
    #10;
    check_regs("reset");

    for (int m = 1; m <= 12; m++) begin
      month = 4'(m);
      #10;
      check($sformatf("d_m%0d", m), 32'(d), 32'(d_tab[m-1]));
    end

    for (int lp = 0; lp < 2; lp++) begin
      for (int m = 0; m < 16; m++) begin
        month = 4'(m); leap = 1'(lp);
        #10;
        check($sformatf("days_m%0d_l%0d", m, lp), 32'(days), 32'(ref_days(4'(m), 1'(lp))));
        check($sformatf("inv_m%0d", m), 32'(invalid), 32'((m == 0 || m > 12) ? 1 : 0));
      end
    end

    for (int i = 0; i < 3; i++) begin
      month = ill[i];
      #10;
      check($sformatf("ill_d_m%0d", ill[i]), 32'(d), 32'd0);
    end

    // Reset overrides enable across a clock edge.
    month = 4'd1; leap = 1'b0; en = 1'b1;
    clk_run = 1'b1;
    @(posedge clk); #1;
    check_regs("rst_over_en");
    #2 rst = 1'b0;

    for (int m = 1; m <= 12; m++) begin
      month = 4'(m);
      tick($sformatf("mon%0d", m));
    end
    check("cnt_after_year", 32'(big_cnt), 32'd7);

    for (int i = 0; i < 3; i++) begin
      month = ill[i];
      tick($sformatf("ill%0d", ill[i]));
    end
    check("ill_invalid_q", 32'(invalid_q), 32'd1);
    check("ill_cnt", 32'(big_cnt), 32'd7);

    en = 1'b0;
    for (int m = 1; m <= 6; m++) begin
      month = 4'(m * 2);
      tick($sformatf("hold%0d", m));
    end

    // Wrap: clear, then 256 enabled 31-day cycles.
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    check_regs("pulse_rst");
    en = 1'b1; month = 4'd7;
    for (int i = 0; i < 255; i++) tick("wrap");
    check("cnt_255", 32'(big_cnt), 32'd255);
    tick("wrap256");
    check("cnt_wrap0", 32'(big_cnt), 32'd0);

    // Asynchronous reset mid-count, observed before the next edge.
    month = 4'd12;
    for (int i = 0; i < 3; i++) tick("precount");
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_regs("async_rst");
    check("async_rst_d", 32'(d), 32'd1);
    check("async_rst_days", 32'(days), 32'd31);
    #1 rst = 1'b0;
    tick("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
